// File: rtl/led_pwm_driver_pkg.sv
// Shared defaults, the PWM full-scale constant and the brightness level type
// for the LED PWM output stage.
package bbcpu_led_pkg;

    localparam int DEF_LED_COUNT = 5;
    localparam int DEF_PWM_BITS  = 4;
    localparam int DEF_PRESCALE  = 1200;

    // Full-scale level for a given resolution; also the PWM period in ticks.
    function automatic int pwm_max(input int bits);
        return (1 << bits) - 1;
    endfunction

    localparam int PWM_MAX = pwm_max(DEF_PWM_BITS);

    typedef logic [DEF_PWM_BITS-1:0] led_level_t;

endpackage

// File: rtl/led_pwm_driver_if.sv
// CPU-side LED pattern/brightness inputs and pin-side outputs of the PWM driver.
// master = pattern source, slave = led_pwm_driver.
interface led_pwm_driver_if
    import bbcpu_led_pkg::*;
#(
    parameter int LED_COUNT = DEF_LED_COUNT,
    parameter int PWM_BITS  = DEF_PWM_BITS
);
    logic [LED_COUNT-1:0] led_in;
    logic [PWM_BITS-1:0]  brightness;
    logic [LED_COUNT-1:0] leds;
    logic                 frame_start;

    modport master (
        output led_in,
        output brightness,
        input  leds,
        input  frame_start
    );

    modport slave (
        input  led_in,
        input  brightness,
        output leds,
        output frame_start
    );
endinterface

// File: rtl/led_pwm_driver_channel.sv
// One LED channel: target mux, level register and registered PWM compare.
// With LED_FADE_EN defined the level ramps by one step per frame toward target.
module led_channel
    import bbcpu_led_pkg::*;
#(
    parameter int PWM_BITS = DEF_PWM_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_evt_i,
    input  logic                pat_bit_i,
    input  logic [PWM_BITS-1:0] bri_i,
    input  logic [PWM_BITS-1:0] pwm_cnt_nxt_i,
    output logic                led_o
);

    logic [PWM_BITS-1:0] target;
    logic [PWM_BITS-1:0] level_q, level_d;
    logic                led_q, led_d;

    assign target = pat_bit_i ? bri_i : '0;

`ifdef LED_FADE_EN
    always_comb begin
        level_d = level_q;
        if (frame_evt_i) begin
            if (level_q < target) begin
                level_d = level_q + PWM_BITS'(1);
            end else if (level_q > target) begin
                level_d = level_q - PWM_BITS'(1);
            end
        end
    end
`else
    always_comb begin
        level_d = level_q;
        if (frame_evt_i) begin
            level_d = target;
        end
    end
`endif

    // Compare against next-cycle counter and level so the pin changes in the
    // same cycle as frame_start instead of one cycle later.
    assign led_d = (pwm_cnt_nxt_i < level_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
            led_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            led_q   <= led_d;
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/led_pwm_driver.sv
// LED PWM output stage: pattern synchroniser, prescaler, frame counter, frame
// shadows and LED_COUNT output channels. Optional fading under LED_FADE_EN.
module led_pwm_driver
    import bbcpu_led_pkg::*;
#(
    parameter int LED_COUNT = DEF_LED_COUNT,
    parameter int PWM_BITS  = DEF_PWM_BITS,
    parameter int PRESCALE  = DEF_PRESCALE
) (
    input  logic              clk,
    input  logic              rst_n,
    led_pwm_driver_if.slave   bus
);

    localparam int PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSC_W-1:0]    PSC_LAST = PSC_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'(pwm_max(PWM_BITS) - 1);

    logic [PSC_W-1:0]     psc_q, psc_d;
    logic [PWM_BITS-1:0]  pwm_cnt_q, pwm_cnt_d;
    logic [LED_COUNT-1:0] sync1_q, pat_sync_q;
    logic [LED_COUNT-1:0] pat_shadow_q, pat_shadow_d;
    logic [PWM_BITS-1:0]  bri_shadow_q, bri_shadow_d;
    logic                 frame_start_q;
    logic                 tick;
    logic                 frame_evt;
    logic [LED_COUNT-1:0] leds_w;

    always_comb begin
        tick      = (psc_q == PSC_LAST);
        psc_d     = tick ? '0 : psc_q + PSC_W'(1);
        frame_evt = tick && (pwm_cnt_q == CNT_LAST);
        pwm_cnt_d = pwm_cnt_q;
        if (tick) begin
            pwm_cnt_d = frame_evt ? '0 : pwm_cnt_q + PWM_BITS'(1);
        end
        // Shadows only move on a frame wrap, so mid-frame input changes wait.
        pat_shadow_d = frame_evt ? pat_sync_q     : pat_shadow_q;
        bri_shadow_d = frame_evt ? bus.brightness : bri_shadow_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_q         <= '0;
            pwm_cnt_q     <= '0;
            sync1_q       <= '0;
            pat_sync_q    <= '0;
            pat_shadow_q  <= '0;
            bri_shadow_q  <= '0;
            frame_start_q <= 1'b0;
        end else begin
            psc_q         <= psc_d;
            pwm_cnt_q     <= pwm_cnt_d;
            sync1_q       <= bus.led_in;
            pat_sync_q    <= sync1_q;
            pat_shadow_q  <= pat_shadow_d;
            bri_shadow_q  <= bri_shadow_d;
            frame_start_q <= frame_evt;
        end
    end

    for (genvar gi = 0; gi < LED_COUNT; gi++) begin : gen_ch
        led_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .frame_evt_i   (frame_evt),
            .pat_bit_i     (pat_shadow_d[gi]),
            .bri_i         (bri_shadow_d),
            .pwm_cnt_nxt_i (pwm_cnt_d),
            .led_o         (leds_w[gi])
        );
    end

    assign bus.leds        = leds_w;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_led_pwm_driver.sv
// Directed bench for led_pwm_driver with a per-frame scoreboard of latched
// pattern/brightness and a frame-level LED model (fading under LED_FADE_EN).
module tb_led_pwm_driver;
    import bbcpu_led_pkg::*;

    localparam int LC    = 5;
    localparam int PB    = 4;
    localparam int PS    = 2;
    localparam int FRAME = PS * ((1 << PB) - 1);

    typedef struct packed {
        logic [LC-1:0] pat;
        led_level_t    bri;
    } frame_exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    led_pwm_driver_if #(.LED_COUNT(LC), .PWM_BITS(PB)) bus ();

    led_pwm_driver #(
        .LED_COUNT (LC),
        .PWM_BITS  (PB),
        .PRESCALE  (PS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    frame_exp_t exp_q[$];
    int model_lvl[LC];
    int pass_cnt  = 0;
    int check_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        check_cnt++;
        assert (obs === exp_v) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    function automatic logic [LC-1:0] model_leds(input int c);
        logic [LC-1:0] r;
        for (int i = 0; i < LC; i++) r[i] = ((c / PS) < model_lvl[i]);
        return r;
    endfunction

    task automatic frame_update(input frame_exp_t e);
        for (int i = 0; i < LC; i++) begin
            int tgt;
            tgt = e.pat[i] ? int'(e.bri) : 0;
`ifdef LED_FADE_EN
            if (model_lvl[i] < tgt) model_lvl[i]++;
            else if (model_lvl[i] > tgt) model_lvl[i]--;
`else
            model_lvl[i] = tgt;
`endif
        end
    endtask

    // Called at the negedge where frame_start is expected high. chg<0 keeps the
    // inputs; a change in the last two cycles misses the synchroniser.
    task automatic run_frame(input logic [LC-1:0] pat, input logic [PB-1:0] bri,
                             input int chg, input int ncyc);
        frame_exp_t e;
        e = '0;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        frame_update(e);
        for (int c = 0; c < ncyc; c++) begin
            check($sformatf("frame_start@c%0d", c), 32'(bus.frame_start), 32'(c == 0));
            check($sformatf("leds@c%0d", c), 32'(bus.leds), 32'(model_leds(c)));
            if (c == 0 && chg < 0) begin
                exp_q.push_back('{bus.led_in, bus.brightness});
            end
            if (c == chg) begin
                if (c >= FRAME - 2) exp_q.push_back('{bus.led_in, bri});
                bus.led_in     = pat;
                bus.brightness = bri;
                exp_q.push_back('{pat, bri});
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_first_frame();
        int n;
        n = 0;
        while (!bus.frame_start && n < FRAME + 10) begin
            check("leds_before_first_frame", 32'(bus.leds), 32'(0));
            @(negedge clk);
            n++;
        end
        check("first_frame_start_cycle", 32'(n), 32'(FRAME));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < LC; i++) model_lvl[i] = 0;
        bus.led_in     = 5'h1F;
        bus.brightness = 4'd15;
        rst_n          = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("reset_leds", 32'(bus.leds), 32'(0));
            check("reset_frame_start", 32'(bus.frame_start), 32'(0));
        end
        exp_q.push_back('{5'h1F, 4'd15});
        rst_n = 1'b1;
        wait_first_frame();

        run_frame(5'b10101, 4'd15, 0, FRAME);   // all on at full brightness
        run_frame(5'b00000, 4'd0, -1, FRAME);   // 10101 steady
        run_frame(5'b10101, 4'd0, 0, FRAME);    // still 10101, brightness -> 0
        run_frame(5'h01, 4'd5, 0, FRAME);       // all dark
        run_frame(5'h02, 4'd5, 10, FRAME);      // LED1 duty 10/30, mid-frame change
        run_frame(5'h1F, 4'd9, 3, FRAME);       // LED2 lights
        run_frame(5'h0C, 4'd15, 5, FRAME);      // duty 18/30 all
        run_frame(5'h11, 4'd15, FRAME - 1, FRAME); // change racing the frame edge
        run_frame(5'h00, 4'd0, -1, FRAME);      // old pattern still latched
        run_frame(5'h00, 4'd0, -1, FRAME / 2);  // new pattern, cut by reset

        rst_n = 1'b0;
        #1;
        check("midreset_leds", 32'(bus.leds), 32'(0));
        check("midreset_frame_start", 32'(bus.frame_start), 32'(0));
        for (int i = 0; i < LC; i++) model_lvl[i] = 0;
        exp_q.delete();
        bus.led_in     = 5'h03;
        bus.brightness = 4'd7;
        repeat (3) begin
            @(negedge clk);
            check("midreset_hold_leds", 32'(bus.leds), 32'(0));
        end
        exp_q.push_back('{5'h03, 4'd7});
        rst_n = 1'b1;
        wait_first_frame();
        run_frame(5'h00, 4'd0, -1, FRAME);

`ifdef LED_FADE_EN
        run_frame(5'h00, 4'd15, 0, FRAME);
        repeat (8) run_frame(5'h00, 4'd0, -1, FRAME);
        run_frame(5'h01, 4'd15, 0, FRAME);
        repeat (7) run_frame(5'h00, 4'd0, -1, FRAME);  // levels 1..7
        run_frame(5'h00, 4'd15, 0, FRAME);             // level 8, clear pattern
        repeat (9) run_frame(5'h00, 4'd0, -1, FRAME);  // 7 down to 0
        run_frame(5'h01, 4'd15, 0, FRAME);
        repeat (16) run_frame(5'h00, 4'd0, -1, FRAME); // full ramp to 15
`endif

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
